// File: rtl/sb_uart_rx.sv
// sb_uart_rx: UART receiver for the SB_IO D_IN_0 pad output.
// Two-flop synchroniser, mid-bit sampling with a down-counter, and a
// one-entry valid/ready holding register with frame/overrun pulses.
// Optional even parity: define SB_UART_RX_PARITY_EN to add the PARITY
// state and the PARITY_ERR port.
module sb_uart_rx #(
   parameter int CLK_DIV   = 104,
   parameter int DATA_BITS = 8
) (
   input  logic                 C,
   input  logic                 R,
   input  logic                 RXD,
   output logic [DATA_BITS-1:0] DATA,
   output logic                 VALID,
   input  logic                 READY,
   output logic                 BUSY,
   output logic                 FRAME_ERR,
   output logic                 OVERRUN
`ifdef SB_UART_RX_PARITY_EN
   ,
   output logic                 PARITY_ERR
`endif
);

   localparam int CW = $clog2(CLK_DIV);
   localparam int IW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF   = CW'(CLK_DIV / 2 - 1);
   localparam logic [IW-1:0] LAST   = IW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   state_t               state, state_n;
   logic                 sync1, rx_s;
   logic [CW-1:0]        cnt, cnt_n, cnt_step;
   logic [IW-1:0]        idx, idx_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic                 sample;
   logic                 deliver;
   logic                 frame_err;
   logic [DATA_BITS-1:0] data_q;
   logic                 valid_q;
   logic                 fe_q;
   logic                 ov_q;
`ifdef SB_UART_RX_PARITY_EN
   logic                 par_bad, par_bad_n;
   logic                 pe_q;
`endif

   assign sample   = (cnt == '0);
   assign cnt_step = sample ? RELOAD : cnt - CW'(1);

   // Two-flop synchroniser for the asynchronous serial line
   always_ff @(posedge C) begin
      if (R) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= RXD;
         rx_s  <= sync1;
      end
   end

   // FSM state, bit timer, bit index and shift register
   always_ff @(posedge C) begin
      if (R) begin
         state <= S_IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
`ifdef SB_UART_RX_PARITY_EN
         par_bad <= 1'b0;
`endif
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         shreg <= shreg_n;
`ifdef SB_UART_RX_PARITY_EN
         par_bad <= par_bad_n;
`endif
      end
   end

   // Next-state logic: start detect, mid-bit sampling, stop/break handling
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      idx_n     = idx;
      shreg_n   = shreg;
      deliver   = 1'b0;
      frame_err = 1'b0;
`ifdef SB_UART_RX_PARITY_EN
      par_bad_n = par_bad;
`endif
      case (state)
         S_IDLE: begin
            if (!rx_s) begin
               state_n = S_START;
               cnt_n   = HALF;
            end
         end
         S_START: begin
            cnt_n = cnt_step;
            if (sample) begin
               state_n = rx_s ? S_IDLE : S_DATA;
               idx_n   = '0;
            end
         end
         S_DATA: begin
            cnt_n = cnt_step;
            if (sample) begin
               shreg_n[idx] = rx_s;
               if (idx == LAST) begin
`ifdef SB_UART_RX_PARITY_EN
                  state_n = S_PARITY;
`else
                  state_n = S_STOP;
`endif
               end else begin
                  idx_n = idx + IW'(1);
               end
            end
         end
`ifdef SB_UART_RX_PARITY_EN
         S_PARITY: begin
            cnt_n = cnt_step;
            if (sample) begin
               par_bad_n = rx_s ^ (^shreg);
               state_n   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            cnt_n = cnt_step;
            if (sample) begin
               if (rx_s) begin
                  deliver = 1'b1;
                  state_n = S_IDLE;
               end else begin
                  frame_err = 1'b1;
                  state_n   = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            if (rx_s) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Holding register with valid/ready handshake and error pulses
   always_ff @(posedge C) begin
      if (R) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         fe_q    <= 1'b0;
         ov_q    <= 1'b0;
`ifdef SB_UART_RX_PARITY_EN
         pe_q    <= 1'b0;
`endif
      end else begin
         fe_q <= frame_err;
         ov_q <= 1'b0;
`ifdef SB_UART_RX_PARITY_EN
         pe_q <= deliver & par_bad;
`endif
         if (deliver) begin
            if (!valid_q || READY) begin
               data_q  <= shreg;
               valid_q <= 1'b1;
            end else begin
               ov_q <= 1'b1;
            end
         end else if (valid_q && READY) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign DATA      = data_q;
   assign VALID     = valid_q;
   assign BUSY      = (state != S_IDLE);
   assign FRAME_ERR = fe_q;
   assign OVERRUN   = ov_q;
`ifdef SB_UART_RX_PARITY_EN
   assign PARITY_ERR = pe_q;
`endif

endmodule
